// File: rtl/reg_list_writer.sv
// Register-list write sequencer: walks the set bits of a register mask and issues
// one register-file write (or synchronous clear) per listed register.
// Define REG_LIST_DESCENDING_EN to visit the highest listed register first.
module reg_list_writer #(
  parameter int WordLen   = 32,
  parameter int WordCount = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WordCount-1:0]           regList,
  input  logic                           clearMode,
  input  logic [WordLen-1:0]             dataIn,
  input  logic                           dataValid,
  output logic                           dataReady,
  output logic [$clog2(WordCount)-1:0]   writeRegister,
  output logic [WordLen-1:0]             writeData,
  output logic                           regWrite,
  output logic                           sclr,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(WordCount+1)-1:0] writeCount
);

  localparam int IdxW = $clog2(WordCount);
  localparam int CntW = $clog2(WordCount + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WordCount-1:0] mask_q, mask_d;
  logic                 clear_q, clear_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [IdxW-1:0]      sel_idx;
  logic [WordCount-1:0] sel_onehot;
  logic                 sel_last;
  logic                 in_run;
  logic                 xfer;

  // Priority pick of the next register; later loop iterations win.
  always_comb begin
    sel_idx = '0;
`ifdef REG_LIST_DESCENDING_EN
    for (int i = 0; i < WordCount; i++) begin
      if (mask_q[i]) sel_idx = IdxW'(i);
    end
`else
    for (int i = WordCount - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_idx = IdxW'(i);
    end
`endif
  end

  assign sel_onehot = WordCount'(1) << sel_idx;
  assign sel_last   = ((mask_q & ~sel_onehot) == '0);
  assign in_run     = (state_q == ST_RUN);
  // Clear mode never waits on data: every RUN cycle retires one register.
  assign xfer       = in_run && (clear_q || dataValid);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    clear_d = clear_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = regList;
          clear_d = clearMode;
          count_d = '0;
          state_d = (regList == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          mask_d  = mask_q & ~sel_onehot;
          count_d = count_q + CntW'(1);
          if (sel_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      clear_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      clear_q <= clear_d;
      count_q <= count_d;
    end
  end

  // Strobes are combinational so the register file can capture them mid-cycle.
  assign dataReady     = in_run && !clear_q;
  assign regWrite      = in_run && !clear_q && dataValid;
  assign sclr          = in_run && clear_q;
  assign writeRegister = in_run ? sel_idx : '0;
  assign writeData     = (in_run && !clear_q) ? dataIn : '0;
  assign busy          = in_run;
  assign done          = (state_q == ST_DONE);
  assign writeCount    = count_q;

endmodule

// File: tb/tb_reg_list_writer.sv
// Directed bench for reg_list_writer with a falling-edge register-file model.
// Ordering checks follow REG_LIST_DESCENDING_EN when it is defined.
module tb_reg_list_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] regList;
  logic        clearMode;
  logic [31:0] dataIn;
  logic        dataValid;
  logic        dataReady;
  logic [3:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic        sclr;
  logic        busy;
  logic        done;
  logic [3:0]  writeCount;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [15];
  logic        rf_wipe = 1'b0;
  int          rf_wr_cnt = 0;
  int          rf_clr_cnt = 0;
  int          clr_idx [3] = '{0, 1, 14};

  always #5 clk = ~clk;

  reg_list_writer dut (
    .clk(clk), .rst(rst), .start(start), .regList(regList), .clearMode(clearMode),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
    .sclr(sclr), .busy(busy), .done(done), .writeCount(writeCount)
  );

  // Register file captures strobes on the falling edge; wipe loads a known pattern.
  always @(negedge clk) begin
    if (rf_wipe) begin
      for (int i = 0; i < 15; i++) rf[i] <= 32'hD0D0_0000 | 32'(i);
      rf_wr_cnt  <= 0;
      rf_clr_cnt <= 0;
    end else begin
      if (regWrite && writeRegister < 4'd15) begin
        rf[writeRegister] <= writeData;
        rf_wr_cnt <= rf_wr_cnt + 1;
      end
      if (sclr && writeRegister < 4'd15) begin
        rf[writeRegister] <= '0;
        rf_clr_cnt <= rf_clr_cnt + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wipe_rf();
    rf_wipe = 1'b1;
    @(negedge clk);
    #1 rf_wipe = 1'b0;
    tick();
  endtask

  task automatic start_xfer(input logic [14:0] mask, input logic clr);
    start     = 1'b1;
    regList   = mask;
    clearMode = clr;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; regList = '0; clearMode = 1'b0;
    dataIn = '0; dataValid = 1'b0;
    #1;
    check_val("reset_outs",
              32'({dataReady, writeRegister, regWrite, sclr, busy, done, writeCount}), 32'h0);
    check_val("reset_wdata", writeData, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Write mode, back-to-back data
    wipe_rf();
    dataValid = 1'b1; dataIn = 32'hAAAA_0001;
    start_xfer(15'h0005, 1'b0);
    #1;
    check_val("w1_regwrite", 32'(regWrite), 32'h1);
    check_val("w1_idx0", 32'(writeRegister), 32'h0);
    check_val("w1_wdata", writeData, 32'hAAAA_0001);
    check_val("w1_ready_busy", 32'({dataReady, busy}), 32'h3);
    tick();
    dataIn = 32'hBBBB_0002;
    #1;
    check_val("w1_idx2", 32'(writeRegister), 32'h2);
    tick();
    dataValid = 1'b0;
    #1;
    check_val("w1_done", 32'({done, busy, regWrite}), 32'h4);
    check_val("w1_count", 32'(writeCount), 32'h2);
    tick();
    check_val("w1_done_off", 32'(done), 32'h0);
    check_val("w1_count_hold", 32'(writeCount), 32'h2);
    check_val("w1_r0", rf[0], 32'hAAAA_0001);
    check_val("w1_r2", rf[2], 32'hBBBB_0002);
    check_val("w1_r1", rf[1], 32'hD0D0_0001);
    $display("scenario write_back_to_back complete");

    // Write mode with a 3-cycle stall; start during RUN must be ignored
    wipe_rf();
    dataValid = 1'b1; dataIn = 32'hAAAA_0001;
    start_xfer(15'h0005, 1'b0);
    tick();
    dataValid = 1'b0; start = 1'b1; regList = 15'h7FFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("w2_stall", 32'({regWrite, busy, writeRegister}), 32'h12);
      tick();
      start = 1'b0;
    end
    dataValid = 1'b1; dataIn = 32'hBBBB_0002;
    #1;
    check_val("w2_resume", 32'({regWrite, writeRegister}), 32'h12);
    tick();
    dataValid = 1'b0;
    #1;
    check_val("w2_done", 32'({done, writeCount}), 32'h12);
    tick();
    check_val("w2_r0", rf[0], 32'hAAAA_0001);
    check_val("w2_r2", rf[2], 32'hBBBB_0002);
    check_val("w2_wr_cnt", 32'(rf_wr_cnt), 32'd2);
    $display("scenario write_stall complete");

    // Clear mode
    wipe_rf();
    dataValid = 1'b1; dataIn = 32'hFFFF_FFFF;
    start_xfer(15'h4003, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("c_sclr_idx", 32'({sclr, writeRegister}), 32'h10 | 32'(clr_idx[k]));
      check_val("c_ready_wr", 32'({dataReady, regWrite}), 32'h0);
      check_val("c_wdata", writeData, 32'h0);
      tick();
    end
    #1;
    check_val("c_done", 32'({done, sclr, writeCount}), 32'h23);
    tick();
    check_val("c_r0", rf[0], 32'h0);
    check_val("c_r1", rf[1], 32'h0);
    check_val("c_r14", rf[14], 32'h0);
    check_val("c_r2", rf[2], 32'hD0D0_0002);
    check_val("c_counts", 32'({16'(rf_clr_cnt), 16'(rf_wr_cnt)}), 32'h0003_0000);
    $display("scenario clear_mode complete");

    // Empty list
    wipe_rf();
    dataValid = 1'b0;
    start_xfer(15'h0000, 1'b0);
    #1;
    check_val("e_done", 32'({done, busy, regWrite, sclr, writeCount}), 32'h80);
    tick();
    check_val("e_done_off", 32'(done), 32'h0);
    check_val("e_counts", 32'(rf_wr_cnt + rf_clr_cnt), 32'h0);
    $display("scenario empty_list complete");

    // Reset mid-transfer
    wipe_rf();
    dataValid = 1'b1; dataIn = 32'h44;
    start_xfer(15'h00F0, 1'b0);
    #1;
    check_val("r_idx4", 32'(writeRegister), 32'h4);
    tick();
    dataIn = 32'h55;
    tick();
    dataIn = 32'h66;
    rst = 1'b1;
    #1;
    check_val("r_outs",
              32'({dataReady, writeRegister, regWrite, sclr, busy, done, writeCount}), 32'h0);
    check_val("r_wdata", writeData, 32'h0);
    tick();
    rst = 1'b0;
    check_val("r_r4", rf[4], 32'h44);
    check_val("r_r5", rf[5], 32'h55);
    check_val("r_r6", rf[6], 32'hD0D0_0006);
    check_val("r_wr_cnt", 32'(rf_wr_cnt), 32'd2);
    dataIn = 32'h77;
    start_xfer(15'h0001, 1'b0);
    #1;
    check_val("r_restart", 32'({regWrite, busy, writeRegister}), 32'h30);
    tick();
    dataValid = 1'b0;
    #1;
    check_val("r_restart_done", 32'({done, writeCount}), 32'h11);
    tick();
    check_val("r_r0", rf[0], 32'h77);
    $display("scenario reset_mid_transfer complete");

    // Visit order
    wipe_rf();
    dataValid = 1'b1; dataIn = 32'h11;
    start_xfer(15'h0012, 1'b0);
    tick();
    dataIn = 32'h22;
    tick();
    dataValid = 1'b0;
    tick();
`ifdef REG_LIST_DESCENDING_EN
    check_val("o_r4", rf[4], 32'h11);
    check_val("o_r1", rf[1], 32'h22);
`else
    check_val("o_r1", rf[1], 32'h11);
    check_val("o_r4", rf[4], 32'h22);
`endif
    $display("scenario order complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_list_writer.md
Name: reg_list_writer

Overview:
- Block-transfer write sequencer that drives the write port of the processor register file.
- Accepts a register-list mask plus a stream of data words.
- Issues one register write per accepted word, walking the set bits of the mask in order (LDM-style multi-register writeback).
- Also offers a clear mode that zeroes every listed register through the register file's synchronous-clear input, without consuming data.

Parameters:
- WordLen, 32, data word width in bits.
- WordCount, 15, number of architectural registers; mask width and index range.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a transfer when in IDLE.
- regList  input  WordCount  register mask; bit i set means register i is written. Sampled with start.
- clearMode  input  1  sampled with start; 1 means clear the listed registers instead of writing data.
- dataIn  input  WordLen  data word for the current register.
- dataValid  input  1  dataIn is valid.
- dataReady  output  1  block accepts dataIn this cycle.
- writeRegister  output  $clog2(WordCount)  index of the register being written or cleared.
- writeData  output  WordLen  data to the register file.
- regWrite  output  1  write strobe to the register file.
- sclr  output  1  clear strobe to the register file.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- writeCount  output  $clog2(WordCount+1)  number of registers written or cleared in the current or last transfer.

Behaviour:
- Reset (async, immediate):
  - State is IDLE and the pending mask is 0.
  - writeCount = 0.
  - dataReady, regWrite, sclr, busy and done are all 0.
  - writeRegister = 0 and writeData = 0.
- States are IDLE, RUN and DONE. The pending mask is a WordCount-bit register.
- IDLE:
  - On start=1, latch regList into the pending mask, latch clearMode, and clear writeCount to 0.
  - If regList == 0, go to DONE. Otherwise go to RUN.
- RUN:
  - busy = 1.
  - writeRegister is the index of the lowest set bit of the pending mask. This is combinational from registered state.
  - Write mode:
    - dataReady = 1 and regWrite = dataValid.
    - writeData = dataIn (combinational pass-through).
    - A transfer occurs when dataValid && dataReady.
  - Clear mode:
    - dataReady = 0, regWrite = 0, sclr = 1, writeData = 0.
    - Each RUN cycle is one transfer; data is never consumed.
  - On each transfer at the rising edge:
    - Clear that bit in the pending mask.
    - Increment writeCount.
    - If it was the last set bit, go to DONE.
  - With dataValid = 0 in write mode, the block stalls: state is held and regWrite = 0.
- Timing with the register file:
  - Strobes are valid for the whole cycle.
  - The register file captures them on the falling edge inside the same cycle.
  - Write latency is therefore half a cycle from the accepting cycle.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - Go to IDLE next cycle.
  - writeCount holds its value until the next start.
- start while in RUN or DONE is ignored; regList and clearMode are not resampled.
- regWrite and sclr are never both 1.
- Outside RUN, regWrite, sclr and dataReady are 0.
- Mask bits at or above WordCount do not exist. writeCount saturates naturally at WordCount; there is no wrap-around.
- Reset asserted mid-transfer aborts immediately:
  - No further strobes are issued.
  - A partially written list is not rolled back.

Optional Feature:
- Macro: REG_LIST_DESCENDING_EN.
- When defined, RUN selects the highest set bit of the pending mask first, giving descending register order (STMDB/LDMDA-style ordering).
- When undefined, order is ascending, lowest bit first.
- All other behaviour, counts and handshakes are identical in both builds.

Test Plan:
- Write mode, regList = 0x0005, dataIn stream 0xAAAA0001 then 0xBBBB0002 with dataValid held high:
  - R0 = 0xAAAA0001, R2 = 0xBBBB0002.
  - done pulses 2 cycles after the first RUN cycle; writeCount = 2.
- Same list with dataValid low for 3 cycles between the words:
  - regWrite = 0 and writeRegister = 2 held during the stall.
  - Final values as in the previous scenario; busy stays high throughout.
- Clear mode, regList = 0x4003:
  - sclr is high for 3 cycles with writeRegister = 0, 1, 14.
  - dataReady stays 0; writeCount = 3.
- start with regList = 0:
  - No strobes; done = 1 on the cycle after start; writeCount = 0.
- Reset mid-transfer:
  - regList = 0x00F0 in write mode, rst asserted after the second accepted word.
  - All outputs are 0 immediately; only R4 and R5 are written; the next start is accepted normally.
- With REG_LIST_DESCENDING_EN defined, regList = 0x0012 and data 0x11, 0x22:
  - R4 = 0x11, R1 = 0x22.
